// File: rtl/dmem_bridge.sv
// Data-memory bridge: posted-write FIFO for stores, stalling reads for loads,
// in front of a handshaked word-addressed bus with registered request signals.
module dmem_bridge #(
  parameter int MIPS_SIZE  = 32,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [MIPS_SIZE-1:0] ALUResult,
  input  logic [MIPS_SIZE-1:0] WriteData,
  output logic [MIPS_SIZE-1:0] ReadData,
  output logic                 Stall,
  output logic                 wbuf_empty,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MIPS_SIZE-3:0] mem_addr,
  output logic [MIPS_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [MIPS_SIZE-1:0] mem_rdata
);
  // state | meaning
  // IDLE  | no transfer on the bus
  // WRITE | head FIFO entry on the bus
  // READ  | load on the bus, core stalled
  // RDONE | load data captured, load retires this cycle
  localparam int AW = MIPS_SIZE - 2;
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RDONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [AW-1:0]        r_fifo_addr [WBUF_DEPTH];
  logic [MIPS_SIZE-1:0] r_fifo_data [WBUF_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
  logic [CW-1:0]        r_count;
  logic                 r_mem_req, w_req_nxt;
  logic                 r_mem_we, w_we_nxt;
  logic [AW-1:0]        r_mem_addr, w_addr_nxt;
  logic [MIPS_SIZE-1:0] r_mem_wdata, w_wdata_nxt;
  logic [MIPS_SIZE-1:0] r_read_data, w_rdata_nxt;
  logic                 w_full, w_empty, w_load, w_enq, w_pop;
  logic                 w_unused;

  assign w_full       = (r_count == CW'(WBUF_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_load       = MemRead & ~MemWrite;
  assign w_enq        = MemWrite & ~w_full;
  assign w_pop        = (r_state == S_WRITE) & mem_ack;
  assign w_rd_ptr_inc = r_rd_ptr + PW'(1);
  assign w_unused     = ^ALUResult[1:0];

  // Stall depends on registered state only, never on mem_ack.
  assign Stall      = RST & ((MemWrite & w_full) | (w_load & (r_state != S_RDONE)));
  assign wbuf_empty = w_empty;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign ReadData   = r_read_data;

  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_fifo_addr[r_wr_ptr] <= ALUResult[MIPS_SIZE-1:2];
      r_fifo_data[r_wr_ptr] <= WriteData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_read_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_read_data <= w_rdata_nxt;
    end
  end

  // A store arriving with nothing else queued goes straight onto the bus.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_mem_req;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_rdata_nxt = r_read_data;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_WRITE;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_fifo_addr[r_rd_ptr];
          w_wdata_nxt = r_fifo_data[r_rd_ptr];
        end else if (w_enq) begin
          w_state_nxt = S_WRITE;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = ALUResult[MIPS_SIZE-1:2];
          w_wdata_nxt = WriteData;
        end else if (w_load) begin
          w_state_nxt = S_READ;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = ALUResult[MIPS_SIZE-1:2];
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          if (r_count > CW'(1)) begin
            w_addr_nxt  = r_fifo_addr[w_rd_ptr_inc];
            w_wdata_nxt = r_fifo_data[w_rd_ptr_inc];
          end else if (w_enq) begin
            w_addr_nxt  = ALUResult[MIPS_SIZE-1:2];
            w_wdata_nxt = WriteData;
          end else begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
            w_we_nxt    = 1'b0;
          end
        end
      end
      S_READ: begin
        if (mem_ack) begin
          w_state_nxt = S_RDONE;
          w_req_nxt   = 1'b0;
          w_rdata_nxt = mem_rdata;
        end
      end
      S_RDONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the single-cycle datapath's memory port and a handshaked word-addressed memory bus. Stores are buffered in a small posted-write FIFO and complete without stalling unless the FIFO is full. Loads drain the FIFO, run a bus read, and stall the core until data returns. It takes the datapath's ALUResult and WriteData outputs and drives its ReadData input. Its Stall output freezes the PC and suppresses RegWrite.

## Interface
- MIPS_SIZE, 32, data and byte-address width
- WBUF_DEPTH, 2, write-buffer entries; power of 2, ≥2

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store
- ALUResult  in  MIPS_SIZE  byte address; bits [1:0] ignored
- WriteData  in  MIPS_SIZE  store data
- ReadData  out  MIPS_SIZE  load data to the write-back mux
- Stall  out  1  core must hold PC and gate RegWrite/MemWrite effects
- wbuf_empty  out  1  write FIFO empty
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write, 0 = read, registered
- mem_addr  out  MIPS_SIZE-2  word address, registered
- mem_wdata  out  MIPS_SIZE  write data, registered
- mem_ack  in  1  transfer complete, sampled at CLK edge while mem_req=1
- mem_rdata  in  MIPS_SIZE  read data, valid with mem_ack on reads

## Operation
- FSM states: IDLE, WRITE (head FIFO entry on bus), READ (load on bus), RDONE (load data ready).
- Store (MemWrite=1, FIFO not full): the entry {ALUResult[31:2], WriteData} is enqueued at the edge. Stall=0.
- Store with FIFO full: Stall=1. Stall is derived from the registered count only; there is no combinational path from mem_ack. Enqueue happens at the first edge where the FIFO is not full.
- MemRead=1 and MemWrite=1 together: handled as a store; MemRead ignored.
- Load (MemRead=1, MemWrite=0), not in RDONE: Stall=1.
  - When in IDLE with the FIFO empty, go to READ and load mem_addr=ALUResult[31:2].
  - The core holds ALUResult stable while stalled.
- Ordering: loads never bypass buffered stores. The FIFO must be empty before READ is entered. There is no store-to-load forwarding.
- Drain: in IDLE with the FIFO non-empty, go to WRITE with the head entry. On mem_ack, pop the head.
  - If another entry remains, stay in WRITE with the next entry; mem_req stays high.
  - Otherwise return to IDLE.
- READ: on mem_ack, capture mem_rdata into ReadData and go to RDONE.
- RDONE: Stall=0 and ReadData holds the captured word, so the load retires at this edge. Return to IDLE.
- ReadData holds its last captured value in all other states.
- The FIFO is a circular buffer with log2(WBUF_DEPTH)-bit pointers that wrap, plus a count of width log2(WBUF_DEPTH)+1.
  - Enqueue and pop in the same edge are both allowed; the count is unchanged.
- Bus rule: while mem_req=1, mem_we, mem_addr and mem_wdata are stable until the edge where mem_ack=1. mem_ack while mem_req=0 is ignored.

## Timing
- Reset (RST=0) takes effect immediately. It clears the FSM to IDLE, empties the FIFO and discards buffered stores.
  - Outputs under reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0, Stall=0, wbuf_empty=1.
- Reset mid-transaction drops mem_req asynchronously. The bus must tolerate an abandoned request.
- Store with space available: 0 stall cycles.
- Load with the FIFO empty and ack in the first request cycle: edge 1 enters READ, edge 2 enters RDONE, edge 3 retires the load. Stall is high for 2 cycles.
- Each extra wait cycle on mem_ack adds 1 stall cycle. Each buffered store ahead of a load adds at least 1 cycle, plus 1 IDLE cycle before READ.
- Back-to-back drain: one transfer per acked cycle, with no bubble between entries.

## Test plan
- Reset mid-READ: assert RST=0 while mem_req=1 → mem_req drops the same cycle; after release, all outputs are at reset values and the FIFO is empty.
- Single store to 0x0000_0010, data 0xDEADBEEF, WBUF_DEPTH=2, ack immediate → Stall=0. Next cycle mem_req=1, mem_we=1, mem_addr=0x4, mem_wdata=0xDEADBEEF. wbuf_empty=1 after the ack.
- Three consecutive stores with mem_ack held 0 → the first two enqueue; the third sees Stall=1. Raise ack for 1 cycle → the head pops, the third enqueues at the next edge, and order on the bus is preserved.
- Load from 0x20 with the FIFO empty, ack returned on the 3rd request cycle with mem_rdata=0x12345678 → Stall high for 4 cycles; ReadData=0x12345678 with Stall=0 in the retire cycle.
- Store 0xAA to 0x40 immediately followed by a load from 0x40 → the write is acked before the read request appears; the read goes to mem_addr=0x10 and the load returns the bus data.
- MemRead=MemWrite=1 at 0x8 → behaves exactly as a store; no read is issued.
